// File: rtl/edit_pkg.sv
// Shared constants, state encoding and bus payloads for the character-cell editor.
// Also holds the cursor-advance and cell-address helpers.
package edit_pkg;

    localparam int unsigned COLS      = 20;
    localparam int unsigned ROWS      = 15;
    localparam int unsigned CELL_LOG2 = 5;
    localparam int unsigned CODE_W    = 7;
    localparam int unsigned H_ACTIVE  = 640;
    localparam int unsigned V_ACTIVE  = 480;

    localparam int unsigned MX_W   = 10;
    localparam int unsigned MY_W   = 9;
    localparam int unsigned COL_W  = 5;
    localparam int unsigned ROW_W  = 4;
    localparam int unsigned ADDR_W = 9;
    localparam int unsigned TMO_W  = 20;

    typedef enum logic [1:0] {
        ST_BROWSE = 2'd0,
        ST_EDIT   = 2'd1,
        ST_RECOG  = 2'd2,
        ST_WRITE  = 2'd3
    } state_e;

    typedef struct packed {
        logic [COL_W-1:0] x;
        logic [ROW_W-1:0] y;
    } cursor_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [CODE_W-1:0] wdata;
    } buf_wr_t;

    // Row-major step through the grid, wrapping from the last cell to (0,0).
    function automatic cursor_t cursor_advance(input cursor_t c);
        cursor_t n;
        n = c;
        if (c.x == COL_W'(COLS - 1)) begin
            n.x = '0;
            if (c.y == ROW_W'(ROWS - 1)) n.y = '0;
            else                         n.y = c.y + ROW_W'(1);
        end else begin
            n.x = c.x + COL_W'(1);
        end
        return n;
    endfunction

    function automatic logic [ADDR_W-1:0] cell_addr(input cursor_t c);
        return ADDR_W'(c.y) * ADDR_W'(COLS) + ADDR_W'(c.x);
    endfunction

endpackage

// File: rtl/edit_cursor_ctrl_btn_edge.sv
// Rising-edge detector for a mouse button level.
// History resets to 1 so a button held through reset yields no edge.
module btn_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic rise_c
);

    logic prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev <= 1'b1;
        else        prev <= btn;
    end

    assign rise_c = btn & ~prev;

endmodule

// File: rtl/edit_cursor_ctrl.sv
// Browse/edit sequencer for the 20x15 character grid: cell selection, canvas clear,
// recogniser handshake with timeout, and text-buffer write with cursor advance.
module edit_cursor_ctrl
    import edit_pkg::*;
#(
    parameter int unsigned RECOG_TIMEOUT = 1048575
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [MX_W-1:0]   mouse_x,
    input  logic [MY_W-1:0]   mouse_y,
    input  logic              mouse_left,
    input  logic              mouse_right,
    input  logic              key_enter,
    input  logic              key_esc,
    input  logic              recog_done,
    input  logic [CODE_W-1:0] recog_code,
    output logic              editing,
    output logic [COL_W-1:0]  writing_block_x_pos,
    output logic [ROW_W-1:0]  writing_block_y_pos,
    output logic              canvas_clear,
    output logic              recog_start,
    output logic              buf_we,
    output logic [ADDR_W-1:0] buf_addr,
    output logic [CODE_W-1:0] buf_wdata,
    output logic              recog_err
);

    state_e            state_q, state_d;
    cursor_t           cur_q, cur_d;
    buf_wr_t           buf_q, buf_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              editing_d, clear_d, start_d, err_d;
    logic              left_rise_c, right_rise_c, on_grid_c;

    btn_edge u_left_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn    (mouse_left),
        .rise_c (left_rise_c)
    );

    btn_edge u_right_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn    (mouse_right),
        .rise_c (right_rise_c)
    );

    assign on_grid_c = (mouse_x < MX_W'(H_ACTIVE)) && (mouse_y < MY_W'(V_ACTIVE));

    // Next-state and next-output logic.
    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        tmo_d    = tmo_q;
        err_d    = recog_err;
        clear_d  = 1'b0;
        start_d  = 1'b0;
        buf_d    = buf_q;
        buf_d.we = 1'b0;

        case (state_q)
            ST_BROWSE: begin
                if (left_rise_c && on_grid_c) begin
                    cur_d.x = COL_W'(mouse_x >> CELL_LOG2);
                    cur_d.y = ROW_W'(mouse_y >> CELL_LOG2);
                    clear_d = 1'b1;
                    state_d = ST_EDIT;
                end
            end
            ST_EDIT: begin
                if (key_esc) begin
                    clear_d = 1'b1;
                    state_d = ST_BROWSE;
                end else if (key_enter || right_rise_c) begin
                    start_d = 1'b1;
                    err_d   = 1'b0;
                    tmo_d   = '0;
                    state_d = ST_RECOG;
                end
            end
            ST_RECOG: begin
                // A done in the final counted cycle still wins over the timeout.
                if (recog_done) begin
                    buf_d.we    = 1'b1;
                    buf_d.addr  = cell_addr(cur_q);
                    buf_d.wdata = recog_code;
                    state_d     = ST_WRITE;
                end else if (tmo_q == TMO_W'(RECOG_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_EDIT;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_WRITE: begin
                clear_d = 1'b1;
                cur_d   = cursor_advance(cur_q);
                state_d = ST_EDIT;
            end
            default: state_d = ST_BROWSE;
        endcase

        editing_d = (state_d != ST_BROWSE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_BROWSE;
            cur_q        <= '0;
            buf_q        <= '0;
            tmo_q        <= '0;
            editing      <= 1'b0;
            canvas_clear <= 1'b0;
            recog_start  <= 1'b0;
            recog_err    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_q        <= cur_d;
            buf_q        <= buf_d;
            tmo_q        <= tmo_d;
            editing      <= editing_d;
            canvas_clear <= clear_d;
            recog_start  <= start_d;
            recog_err    <= err_d;
        end
    end

    assign writing_block_x_pos = cur_q.x;
    assign writing_block_y_pos = cur_q.y;
    assign buf_we              = buf_q.we;
    assign buf_addr            = buf_q.addr;
    assign buf_wdata           = buf_q.wdata;

endmodule

// File: tb/tb_edit_cursor_ctrl.sv
// Randomised plus directed bench for edit_cursor_ctrl against a behavioural grid-editor model.
module tb_edit_cursor_ctrl;

    localparam int TMO = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] mouse_x = '0;
    logic [8:0] mouse_y = '0;
    logic       mouse_left = 1'b0, mouse_right = 1'b0;
    logic       key_enter = 1'b0, key_esc = 1'b0, recog_done = 1'b0;
    logic [6:0] recog_code = '0;

    logic       editing, canvas_clear, recog_start, buf_we, recog_err;
    logic [4:0] writing_block_x_pos;
    logic [3:0] writing_block_y_pos;
    logic [8:0] buf_addr;
    logic [6:0] buf_wdata;

    edit_cursor_ctrl #(.RECOG_TIMEOUT(TMO)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .mouse_x             (mouse_x),
        .mouse_y             (mouse_y),
        .mouse_left          (mouse_left),
        .mouse_right         (mouse_right),
        .key_enter           (key_enter),
        .key_esc             (key_esc),
        .recog_done          (recog_done),
        .recog_code          (recog_code),
        .editing             (editing),
        .writing_block_x_pos (writing_block_x_pos),
        .writing_block_y_pos (writing_block_y_pos),
        .canvas_clear        (canvas_clear),
        .recog_start         (recog_start),
        .buf_we              (buf_we),
        .buf_addr            (buf_addr),
        .buf_wdata           (buf_wdata),
        .recog_err           (recog_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int we_seen = 0;

    // Behavioural model: mode 0 browsing, 1 drawing, 2 awaiting recogniser, 3 writing.
    int m_mode = 0, m_x = 0, m_y = 0, m_wait = 0;
    bit m_pl = 1, m_pr = 1;
    bit e_editing = 0, e_clear = 0, e_start = 0, e_we = 0, e_err = 0;
    int e_addr = 0, e_wdata = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_mode = 0; m_x = 0; m_y = 0; m_wait = 0; m_pl = 1; m_pr = 1;
        e_editing = 0; e_clear = 0; e_start = 0; e_we = 0; e_err = 0;
        e_addr = 0; e_wdata = 0;
    endtask

    task automatic m_step();
        bit lr, rr;
        lr = mouse_left && !m_pl;
        rr = mouse_right && !m_pr;
        m_pl = mouse_left;
        m_pr = mouse_right;
        e_clear = 0; e_start = 0; e_we = 0;
        case (m_mode)
            0: if (lr && int'(mouse_x) < 640 && int'(mouse_y) < 480) begin
                   m_x = int'(mouse_x) / 32;
                   m_y = int'(mouse_y) / 32;
                   e_clear = 1;
                   m_mode = 1;
               end
            1: if (key_esc) begin
                   e_clear = 1;
                   m_mode = 0;
               end else if (key_enter || rr) begin
                   e_start = 1;
                   e_err = 0;
                   m_wait = 0;
                   m_mode = 2;
               end
            2: if (recog_done) begin
                   e_we = 1;
                   e_addr = m_y * 20 + m_x;
                   e_wdata = int'(recog_code);
                   m_mode = 3;
               end else begin
                   m_wait++;
                   if (m_wait == TMO) begin
                       e_err = 1;
                       m_mode = 1;
                   end
               end
            default: begin
                e_clear = 1;
                m_x++;
                if (m_x == 20) begin
                    m_x = 0;
                    m_y = (m_y + 1) % 15;
                end
                m_mode = 1;
            end
        endcase
        e_editing = (m_mode != 0);
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) m_reset();
            else        m_step();
        end
    end

    // Every-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (buf_we) we_seen++;
            chk("editing", int'(editing), int'(e_editing));
            chk("x_pos", int'(writing_block_x_pos), m_x);
            chk("y_pos", int'(writing_block_y_pos), m_y);
            chk("canvas_clear", int'(canvas_clear), int'(e_clear));
            chk("recog_start", int'(recog_start), int'(e_start));
            chk("buf_we", int'(buf_we), int'(e_we));
            chk("recog_err", int'(recog_err), int'(e_err));
            if (e_we) begin
                chk("buf_addr", int'(buf_addr), e_addr);
                chk("buf_wdata", int'(buf_wdata), e_wdata);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic click(input int x, input int y);
        mouse_x = 10'(x); mouse_y = 9'(y); mouse_left = 1'b1;
        step();
        mouse_left = 1'b0;
    endtask

    task automatic pulse_enter();
        key_enter = 1'b1; step(); key_enter = 1'b0;
    endtask

    task automatic pulse_esc();
        key_esc = 1'b1; step(); key_esc = 1'b0;
    endtask

    task automatic pulse_done(input int code);
        recog_done = 1'b1; recog_code = 7'(code); step(); recog_done = 1'b0;
    endtask

    int we_before;

    initial begin
        step(); step();
        chk("rst_editing", int'(editing), 0);
        chk("rst_pos", int'(writing_block_x_pos) + int'(writing_block_y_pos), 0);
        chk("rst_pulses", int'(canvas_clear) + int'(recog_start) + int'(buf_we) + int'(recog_err), 0);
        rst_n = 1'b1;
        step();

        // Click selects cell (3,2).
        click(100, 70);
        chk("t1_editing", int'(editing), 1);
        chk("t1_x", int'(writing_block_x_pos), 3);
        chk("t1_y", int'(writing_block_y_pos), 2);
        chk("t1_clear", int'(canvas_clear), 1);
        step();
        chk("t1_clear_width", int'(canvas_clear), 0);

        // Commit at (5,4) writes 0x41 to address 85.
        pulse_esc();
        chk("t2_esc_browse", int'(editing), 0);
        step();
        click(163, 129);
        pulse_enter();
        chk("t2_start", int'(recog_start), 1);
        step(); step();
        pulse_done(8'h41);
        chk("t2_we", int'(buf_we), 1);
        chk("t2_addr", int'(buf_addr), 85);
        chk("t2_data", int'(buf_wdata), 65);
        step();
        chk("t2_we_width", int'(buf_we), 0);
        chk("t2_adv_x", int'(writing_block_x_pos), 6);
        chk("t2_adv_y", int'(writing_block_y_pos), 4);
        chk("t2_clear", int'(canvas_clear), 1);

        // Last cell writes address 299 and wraps.
        pulse_esc();
        step();
        click(613, 455);
        pulse_enter();
        step();
        pulse_done(8'h22);
        chk("t3_addr", int'(buf_addr), 299);
        chk("t3_data", int'(buf_wdata), 34);
        step();
        chk("t3_wrap_x", int'(writing_block_x_pos), 0);
        chk("t3_wrap_y", int'(writing_block_y_pos), 0);

        // Esc beats enter.
        key_enter = 1'b1; key_esc = 1'b1;
        step();
        key_enter = 1'b0; key_esc = 1'b0;
        chk("t4_editing", int'(editing), 0);
        chk("t4_no_start", int'(recog_start), 0);
        chk("t4_clear", int'(canvas_clear), 1);

        // Timeout after TMO cycles, no write.
        click(10, 10);
        we_before = we_seen;
        pulse_enter();
        repeat (TMO - 1) step();
        chk("t5_err_early", int'(recog_err), 0);
        step();
        chk("t5_err", int'(recog_err), 1);
        chk("t5_editing", int'(editing), 1);
        step();
        chk("t5_no_write", we_seen - we_before, 0);
        chk("t5_err_sticky", int'(recog_err), 1);
        mouse_right = 1'b1;
        step();
        mouse_right = 1'b0;
        chk("t5_right_start", int'(recog_start), 1);
        chk("t5_err_cleared", int'(recog_err), 0);

        // Asynchronous reset while awaiting recognition.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        recog_done = 1'b1; recog_code = 7'h55;
        #1;
        chk("t6_async_editing", int'(editing), 0);
        chk("t6_async_pulses", int'(canvas_clear) + int'(recog_start) + int'(buf_we) + int'(recog_err), 0);
        step();
        recog_done = 1'b0;
        mouse_x = 10'd50; mouse_y = 9'd50; mouse_left = 1'b1;
        step();
        rst_n = 1'b1;
        step(); step();
        chk("t6_held_no_click", int'(editing), 0);
        chk("t6_discarded", int'(buf_we), 0);
        mouse_left = 1'b0;
        step();
        click(700, 10);
        chk("t6_offgrid_x", int'(editing), 0);
        step();
        click(100, 500);
        chk("t6_offgrid_y", int'(editing), 0);
        step();

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            rst_n       = ($urandom % 400) != 0;
            mouse_x     = 10'($urandom_range(0, 720));
            mouse_y     = 9'($urandom_range(0, 511));
            mouse_left  = ($urandom % 3) == 0;
            mouse_right = ($urandom % 9) == 0;
            key_enter   = ($urandom % 6) == 0;
            key_esc     = ($urandom % 25) == 0;
            recog_done  = ($urandom % 7) == 0;
            recog_code  = 7'($urandom);
            step();
        end
        rst_n = 1'b1;
        mouse_left = 1'b0; mouse_right = 1'b0;
        key_enter = 1'b0; key_esc = 1'b0; recog_done = 1'b0;
        step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
